// File: rtl/custom_subtractor47_norm.sv
// Two-stage subtract/normalize pipeline: |A - {0,B}| with sign/zero flags, valid/ready on both sides.
// Optional normalization (leading-zero count + left shift) when CUSTOM_SUB_NORMALIZE_EN is defined.
module custom_subtractor47_norm (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [46:0] A,
    input  logic [45:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [46:0] Diff,
    output logic        Sign,
    output logic [5:0]  Shift,
    output logic        Zero
);

    logic [46:0] b_ext;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q,  s1_sign_d;
    logic        s1_zero_q,  s1_zero_d;
    logic [46:0] s1_mag_q,   s1_mag_d;

    logic        out_valid_q, out_valid_d;
    logic [46:0] diff_q,      diff_d;
    logic        sign_q,      sign_d;
    logic [5:0]  shift_q,     shift_d;
    logic        zero_q,      zero_d;

    logic        adv2;
    logic        adv1;
    logic [46:0] norm_mag;
    logic [5:0]  norm_shift;

    assign b_ext = {1'b0, B};

    // Stage 2 drains when its slot is free or being consumed; stage 1 follows.
    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = !rst && adv1;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_mag_d   = s1_mag_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = (A < b_ext);
                s1_zero_d = (A == b_ext);
                s1_mag_d  = (A < b_ext) ? (b_ext - A) : (A - b_ext);
            end
        end
    end

`ifdef CUSTOM_SUB_NORMALIZE_EN
    // Ascending scan: the last set bit seen is the MSB, giving the leading-zero count.
    always_comb begin
        norm_shift = '0;
        for (int unsigned i = 0; i < 47; i++) begin
            if (s1_mag_q[i]) begin
                norm_shift = 6'(46 - i);
            end
        end
        norm_mag = s1_mag_q << norm_shift;
    end
`else
    always_comb begin
        norm_mag   = s1_mag_q;
        norm_shift = '0;
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        sign_d      = sign_q;
        shift_d     = shift_q;
        zero_d      = zero_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d  = norm_mag;
                sign_d  = s1_sign_q;
                shift_d = norm_shift;
                zero_d  = s1_zero_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_mag_q    <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            sign_q      <= 1'b0;
            shift_q     <= '0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_mag_q    <= s1_mag_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            sign_q      <= sign_d;
            shift_q     <= shift_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Diff      = diff_q;
    assign Sign      = sign_q;
    assign Shift     = shift_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_custom_subtractor47_norm.sv
// Self-checking bench for custom_subtractor47_norm: directed vectors, backpressure, resets, random streaming.
module tb_custom_subtractor47_norm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [46:0] A = '0;
    logic [45:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [46:0] Diff;
    logic        Sign;
    logic [5:0]  Shift;
    logic        Zero;

    int n_cmp = 0;
    int n_err = 0;

    custom_subtractor47_norm dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Diff(Diff), .Sign(Sign), .Shift(Shift), .Zero(Zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {Diff, Sign, Shift, Zero} derived from plain arithmetic.
    function automatic logic [54:0] model(input logic [46:0] a, input logic [45:0] b);
        logic [46:0] be, d;
        logic        s, z;
        logic [5:0]  sh;
        be = {1'b0, b};
        s  = a < be;
        z  = a == be;
        d  = s ? be - a : a - be;
        sh = '0;
`ifdef CUSTOM_SUB_NORMALIZE_EN
        if (d != 0) begin
            while (d[46] == 1'b0) begin
                d  = d << 1;
                sh = sh + 6'd1;
            end
        end
`endif
        return {d, s, sh, z};
    endfunction

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({out_valid, in_ready, Diff, Sign, Shift, Zero} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got ov=%b ir=%b diff=%h s=%b sh=%0d z=%b, want all 0",
                     out_valid, in_ready, Diff, Sign, Shift, Zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ir=%b ov=%b, want ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed_vectors();
        logic [46:0] ta [3];
        logic [45:0] tb [3];
        logic [54:0] te [3];
        ta[0] = 47'h4000_0000_0000; tb[0] = 46'd1;
        ta[1] = 47'd3;              tb[1] = 46'd10;
        ta[2] = 47'd5;              tb[2] = 46'd5;
`ifdef CUSTOM_SUB_NORMALIZE_EN
        te[0] = {47'h7FFF_FFFF_FFFE, 1'b0, 6'd1,  1'b0};
        te[1] = {47'h7000_0000_0000, 1'b1, 6'd44, 1'b0};
`else
        te[0] = {47'h3FFF_FFFF_FFFF, 1'b0, 6'd0,  1'b0};
        te[1] = {47'd7,              1'b1, 6'd0,  1'b0};
`endif
        te[2] = {47'd0, 1'b0, 6'd0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            A = ta[k];
            B = tb[k];
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL dir%0d_in_ready: got %b want 1", k, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_early_valid: got ov=%b want 0 one cycle after input", k, out_valid);
            end
            @(negedge clk);
            n_cmp++;
            if ({out_valid, Diff, Sign, Shift, Zero} !== {1'b1, te[k]}) begin
                n_err++;
                $display("FAIL dir%0d_result: got ov=%b diff=%h s=%b sh=%0d z=%b want ov=1 diff=%h s=%b sh=%0d z=%b",
                         k, out_valid, Diff, Sign, Shift, Zero, te[k][54:8], te[k][7], te[k][6:1], te[k][0]);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_single: got ov=%b want 0 after consumption", k, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [46:0] xa [3];
        logic [45:0] xb [3];
        for (int k = 0; k < 3; k++) begin
            xa[k] = 47'({$urandom(), $urandom()});
            xb[k] = 46'({$urandom(), $urandom()});
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            in_valid = 1'b1;
            A = xa[k];
            B = xb[k];
            #1;
            n_cmp++;
            if (in_ready !== (k < 2)) begin
                n_err++;
                $display("FAIL bp_in_ready%0d: got %b want %b", k, in_ready, (k < 2));
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if ({out_valid, Diff, Sign, Shift, Zero} !== {1'b1, model(xa[0], xb[0])}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got ov=%b diff=%h s=%b sh=%0d z=%b want ov=1 %h",
                         c, out_valid, Diff, Sign, Shift, Zero, model(xa[0], xb[0]));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, Diff, Sign, Shift, Zero} !== {1'b1, model(xa[1], xb[1])}) begin
            n_err++;
            $display("FAIL bp_second: got ov=%b diff=%h s=%b sh=%0d z=%b want ov=1 %h",
                     out_valid, Diff, Sign, Shift, Zero, model(xa[1], xb[1]));
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drained: got ov=%b want 0 (third input was refused)", out_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 47'h1234_5678_9ABC;
        B = 46'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, Diff, Sign, Shift, Zero} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got ov=%b ir=%b diff=%h s=%b sh=%0d z=%b want all 0 before next edge",
                     out_valid, in_ready, Diff, Sign, Shift, Zero);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int seen;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 47'h0FFF_0000_1111;
        B = 46'h0000_2222_3333;
        @(negedge clk);
        A = 47'd9;
        B = 46'd100;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready, Diff, Sign, Shift, Zero} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_state: got ov=%b ir=%b diff=%h s=%b sh=%0d z=%b want all 0",
                     out_valid, in_ready, Diff, Sign, Shift, Zero);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_ready: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL mid_reset_discard: got %0d stale results want 0", seen);
        end
    endtask

    task automatic test_streaming();
        logic [54:0] q[$];
        logic [54:0] held, got, exp;
        logic        hold;
        int          acc, rcv, cyc;
        hold = 1'b0;
        held = '0;
        acc  = 0;
        rcv  = 0;
        cyc  = 0;
        while ((acc < 100 || q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            got = {Diff, Sign, Shift, Zero};
            if (hold) begin
                n_cmp++;
                if (out_valid !== 1'b1 || got !== held) begin
                    n_err++;
                    $display("FAIL stream_hold: got ov=%b %h want ov=1 %h", out_valid, got, held);
                end
            end
            out_ready = (acc >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
            in_valid  = (acc < 100) && ($urandom_range(0, 3) != 0);
            A = 47'({$urandom(), $urandom()});
            B = 46'({$urandom(), $urandom()});
            if ($urandom_range(0, 9) == 0) A = {1'b0, B};
            if ($urandom_range(0, 9) == 0) A = 47'($urandom_range(0, 255));
            #1;
            n_cmp++;
            if (in_ready !== (q.size() < 2 || out_ready)) begin
                n_err++;
                $display("FAIL stream_in_ready: got %b want %b (buffered=%0d out_ready=%b)",
                         in_ready, (q.size() < 2 || out_ready), q.size(), out_ready);
            end
            if (out_valid && out_ready) begin
                exp = (q.size() != 0) ? q.pop_front() : 'x;
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL stream_result%0d: got %h want %h", rcv, got, exp);
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B));
                acc++;
            end
            hold = out_valid && !out_ready;
            held = got;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (rcv != acc || acc != 100 || q.size() != 0) begin
            n_err++;
            $display("FAIL stream_count: got %0d results for %0d accepted (%0d pending) want 100/100/0",
                     rcv, acc, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed_vectors();
        test_backpressure();
        test_async_reset();
        test_reset_midstream();
        test_streaming();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/custom_subtractor47_norm.md
CUSTOM_SUBTRACTOR47_NORM -- requirements
Module: custom_subtractor47_norm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  A/B operand pair valid.
REQ-005 in_ready  output  1  block accepts the operand pair this cycle.
REQ-006 A  input  47  unsigned minuend mantissa.
REQ-007 B  input  46  unsigned subtrahend mantissa, zero-extended to 47 bits internally.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 Diff  output  47  magnitude of the difference, normalized when the option in REQ-026 is compiled in.
REQ-011 Sign  output  1  1 when A < {1'b0,B}.
REQ-012 Shift  output  6  left-shift amount applied during normalization (0..46).
REQ-013 Zero  output  1  1 when A == {1'b0,B}.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 Stage 1 SHALL register Sign, Zero, and raw magnitude |A - {0,B}| (47 bits, no overflow possible).
REQ-016 Stage 2 SHALL produce Diff/Shift from stage-1 data and drive the registered outputs.
REQ-017 Latency SHALL be exactly 2 cycles, from input transfer to out_valid, with out_ready held high; throughput SHALL be 1 result per cycle.
REQ-018 Stage 2 SHALL advance when !out_valid || out_ready; stage 1 SHALL advance when stage 1 is empty or stage 2 advances.
REQ-019 in_ready SHALL be 1 exactly when stage 1 can advance; it is combinational from state and out_ready only, never from in_valid.
REQ-020 While out_valid && !out_ready, Diff/Sign/Shift/Zero SHALL hold stable; at most 2 results buffer internally; none SHALL be dropped or duplicated, and order is preserved.
REQ-021 Normalized Diff = raw << lzc(raw), with bit 46 set; Shift = lzc(raw).
REQ-022 When raw == 0: Diff = 0, Shift = 0, Zero = 1, Sign = 0.

Reset
REQ-023 On rst assertion, regardless of clk, both stage-valid flags and out_valid SHALL clear to 0, and Diff/Sign/Shift/Zero SHALL clear to 0.
REQ-024 in_ready SHALL be 0 while rst is high, and 1 in the first cycle after rst deasserts.
REQ-025 Reset mid-operation SHALL discard all in-flight results; no out_valid SHALL appear for operands accepted before reset.

Configuration
REQ-026 Macro CUSTOM_SUB_NORMALIZE_EN: when defined, stage 2 SHALL perform leading-zero count and left shift per REQ-021.
REQ-027 When CUSTOM_SUB_NORMALIZE_EN is undefined:
- Diff SHALL be the raw magnitude.
- Shift SHALL be constant 0.
- Latency, handshake, Sign and Zero SHALL be identical to the defined case.

Verification
REQ-028 A=47'h4000_0000_0000, B=1 -> 2 cycles later Diff=47'h7FFF_FFFF_FFFE, Shift=1, Sign=0, Zero=0.
REQ-029 A=3, B=10 -> Sign=1, Diff=47'h7000_0000_0000, Shift=44; without the macro, Diff=7, Shift=0.
REQ-030 A=5, B=5 -> Diff=0, Shift=0, Zero=1, Sign=0.
REQ-031 Backpressure:
- Stimulus: out_ready=0, then 3 back-to-back inputs.
- Required: the first 2 are accepted and in_ready falls on the 3rd.
- Required: outputs hold; after out_ready=1, results emerge in order with no loss.
REQ-032 Reset mid-stream: rst asserted for 1 cycle with both stages full -> out_valid=0 next edge; outputs all 0; in_ready=1 after release.
REQ-033 Streaming: 100 random pairs with out_ready randomly toggled -> every result matches the reference model in order, and the count equals the number of accepted inputs.
